alu_muldiv: RTL and testbench
=============================

Name: alu_muldiv

Overview:
- Parametrised iterative multiply/divide unit; next generation of the single-cycle ALU.
- Adds the full RV32M set, including MULH*, DIV* and REM*, which the single-cycle ALU does not implement.
- Uses a radix-2 multi-cycle datapath to save area.
- Sits beside the ALU in the execute stage. Uses a valid/ready handshake so the pipeline stalls while the unit is busy.

Parameters:
- BIT_WIDTH, 32: operand and result width; any even value ≥ 8.
- EARLY_OUT, 1: if 1, divide-by-zero and signed overflow complete in 1 cycle; if 0, they take the full iteration count.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  abort any in-flight or completed-but-unconsumed operation.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  unit can accept an operation (IDLE state).
- op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- in1  in  BIT_WIDTH  rs1 operand.
- in2  in  BIT_WIDTH  rs2 operand.
- out_valid  out  1  result valid (DONE state).
- out_ready  in  1  consumer takes the result.
- out  out  BIT_WIDTH  result; registered.
- div_zero  out  1  the completed op was DIV/DIVU/REM/REMU with in2 == 0; valid with out_valid.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, out = 0, div_zero = 0; all internal registers are cleared.
- rst has priority over flush, and flush has priority over handshakes.
- States: IDLE → BUSY → FIX → DONE → IDLE.
- IDLE:
  - in_ready = 1.
  - Accept when in_valid on an edge. Latch op.
  - Latch |in1| and |in2| (absolute value for signed interpretations: MULH both operands, MULHSU in1 only, DIV/REM both). Latch the result sign.
  - Load step counter = BIT_WIDTH. Go to BUSY.
- Special cases when EARLY_OUT = 1 (the accepting edge goes directly to DONE with out loaded):
  - Div by zero: DIV/DIVU → all-ones; REM/REMU → in1; div_zero = 1.
  - Signed overflow (DIV/REM, in1 = most-negative, in2 = all-ones): DIV → in1, REM → 0.
- Special cases when EARLY_OUT = 0: the same values are produced, but the unit still passes through BUSY and FIX.
- BUSY, multiply: 2·BIT_WIDTH-bit shift-add, one multiplier bit per cycle.
- BUSY, divide: restoring shift-subtract, one quotient bit per cycle.
- BUSY counter: decrements each cycle; at counter = 1 go to FIX.
- FIX:
  - Apply the sign by two's-complement negation.
  - Quotient sign = in1_msb XOR in2_msb. Remainder sign = sign of in1.
  - Select the output: MUL → low half; MULH/MULHSU/MULHU → high half; DIV/DIVU → quotient; REM/REMU → remainder.
  - Register into out. Go to DONE.
- Latency: out_valid rises BIT_WIDTH+2 edges after the accepting edge; 1 edge for early-out.
- DONE:
  - out_valid = 1; out and div_zero are held stable.
  - When out_ready is high on an edge, go to IDLE, out_valid drops, out keeps its value.
  - in_ready = 0 in DONE. No accept-while-draining.
- Backpressure: out_valid stays high indefinitely until out_ready. out must not change while waiting.
- flush in any state: next state IDLE, out_valid = 0, in_ready = 1 next cycle. The aborted result is never presented. in_valid is ignored on the flush edge.
- rst mid-operation: same effect as flush, plus out and div_zero are cleared.
- Arithmetic: all internal arithmetic is unsigned on magnitudes. The most-negative operand's magnitude is represented in BIT_WIDTH bits unsigned, so there is no loss.

Test Plan:
- MUL in1 = 7, in2 = 0xFFFFFFFD → out = 0xFFFFFFEB; out_valid exactly 34 edges after accept; in_ready low throughout.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU → 2.
- DIV 0x12345678 / 0 → 0xFFFFFFFF, div_zero = 1, 1-cycle latency. REM → 0x12345678. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM → 0.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid → out stable, in_ready = 0, a new in_valid is not accepted. Then out_ready = 1 → IDLE next edge.
- flush asserted 10 cycles into DIV → in_ready = 1 next cycle, no out_valid. A subsequent MUL 3 × 5 → 15. rst mid-MUL → all outputs return to reset values.

Source files
------------

// File: rtl/alu_muldiv_if.sv
// Handshake and operand/result bundle between the execute stage and alu_muldiv.
interface alu_muldiv_if #(
  parameter int unsigned BIT_WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           op;
  logic [BIT_WIDTH-1:0] in1;
  logic [BIT_WIDTH-1:0] in2;
  logic                 out_valid;
  logic                 out_ready;
  logic [BIT_WIDTH-1:0] out;
  logic                 div_zero;

  modport master (
    output in_valid, op, in1, in2, out_ready,
    input  in_ready, out_valid, out, div_zero
  );

  modport slave (
    input  in_valid, op, in1, in2, out_ready,
    output in_ready, out_valid, out, div_zero
  );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative radix-2 RV32M multiply/divide unit: shift-add multiply, restoring divide,
// operating on magnitudes with a final sign fix-up.
module alu_muldiv #(
  parameter int unsigned BIT_WIDTH = 32,
  parameter bit          EARLY_OUT = 1'b1
) (
  input logic         clk,
  input logic         rst,
  input logic         flush,
  alu_muldiv_if.slave bus
);
  localparam int unsigned CntW = $clog2(BIT_WIDTH + 1);
  localparam logic [BIT_WIDTH-1:0]   One    = BIT_WIDTH'(1);
  localparam logic [2*BIT_WIDTH-1:0] One2   = (2*BIT_WIDTH)'(1);
  localparam logic [BIT_WIDTH-1:0]   Ones   = '1;
  localparam logic [BIT_WIDTH-1:0]   MinNeg = {1'b1, {(BIT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StBusy, StFix, StDone} state_e;

  state_e               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [BIT_WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, dvs_q, dvs_d;
  logic [BIT_WIDTH-1:0] spec_val_q, spec_val_d, out_q, out_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 neg_q, neg_d, spec_q, spec_d, zero_q, zero_d;
  logic                 div_zero_q, div_zero_d;

  logic                     is_div, sgn1, sgn2, in1_neg, in2_neg, in_zero, in_ovf;
  logic [BIT_WIDTH-1:0]     abs1, abs2, spec_res;
  logic [BIT_WIDTH:0]       mul_sum, div_sh, div_diff;
  logic [2*BIT_WIDTH-1:0]   prod, prod_s;
  logic [BIT_WIDTH-1:0]     dsel, dsel_s, fix_res;

  // Operand decode: which inputs are signed, their magnitudes, and special-case results.
  always_comb begin
    is_div   = bus.op[2];
    sgn1     = is_div ? ~bus.op[0] : (bus.op[1:0] == 2'b01 || bus.op[1:0] == 2'b10);
    sgn2     = is_div ? ~bus.op[0] : (bus.op[1:0] == 2'b01);
    in1_neg  = sgn1 & bus.in1[BIT_WIDTH-1];
    in2_neg  = sgn2 & bus.in2[BIT_WIDTH-1];
    abs1     = in1_neg ? (~bus.in1 + One) : bus.in1;
    abs2     = in2_neg ? (~bus.in2 + One) : bus.in2;
    in_zero  = is_div && (bus.in2 == '0);
    in_ovf   = is_div && !bus.op[0] && (bus.in1 == MinNeg) && (bus.in2 == Ones);
    if (in_zero) spec_res = bus.op[1] ? bus.in1 : Ones;
    else         spec_res = bus.op[1] ? '0 : bus.in1;
  end

  // One iteration step; hi/lo hold {acc, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
    div_sh   = {hi_q, lo_q[BIT_WIDTH-1]};
    div_diff = div_sh - {1'b0, dvs_q};
    prod     = {hi_q, lo_q};
    prod_s   = neg_q ? (~prod + One2) : prod;
    dsel     = op_q[1] ? hi_q : lo_q;
    dsel_s   = neg_q ? (~dsel + One) : dsel;
    if (spec_q)                fix_res = spec_val_q;
    else if (op_q[2])          fix_res = dsel_s;
    else if (op_q[1:0] == '0)  fix_res = prod_s[BIT_WIDTH-1:0];
    else                       fix_res = prod_s[2*BIT_WIDTH-1:BIT_WIDTH];
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    dvs_d      = dvs_q;
    spec_val_d = spec_val_q;
    out_d      = out_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    spec_d     = spec_q;
    zero_d     = zero_q;
    div_zero_d = div_zero_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            op_d       = bus.op;
            hi_d       = '0;
            lo_d       = abs1;
            dvs_d      = abs2;
            neg_d      = (is_div && bus.op[1]) ? in1_neg : (in1_neg ^ in2_neg);
            spec_d     = in_zero | in_ovf;
            spec_val_d = spec_res;
            zero_d     = in_zero;
            cnt_d      = CntW'(BIT_WIDTH);
            if (EARLY_OUT && (in_zero || in_ovf)) begin
              out_d      = spec_res;
              div_zero_d = in_zero;
              state_d    = StDone;
            end else begin
              state_d = StBusy;
            end
          end
        end
        StBusy: begin
          cnt_d = cnt_q - CntW'(1);
          if (op_q[2]) begin
            hi_d = div_diff[BIT_WIDTH] ? div_sh[BIT_WIDTH-1:0] : div_diff[BIT_WIDTH-1:0];
            lo_d = {lo_q[BIT_WIDTH-2:0], ~div_diff[BIT_WIDTH]};
          end else begin
            hi_d = mul_sum[BIT_WIDTH:1];
            lo_d = {mul_sum[0], lo_q[BIT_WIDTH-1:1]};
          end
          if (cnt_q == CntW'(1)) state_d = StFix;
        end
        StFix: begin
          out_d      = fix_res;
          div_zero_d = zero_q;
          state_d    = StDone;
        end
        StDone: begin
          if (bus.out_ready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      dvs_q      <= '0;
      spec_val_q <= '0;
      out_q      <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      spec_q     <= 1'b0;
      zero_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      dvs_q      <= dvs_d;
      spec_val_q <= spec_val_d;
      out_q      <= out_d;
      cnt_q      <= cnt_d;
      neg_q      <= neg_d;
      spec_q     <= spec_d;
      zero_q     <= zero_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.out       = out_q;
  assign bus.div_zero  = div_zero_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// Randomised and directed bench for alu_muldiv against a plain-arithmetic RV32M model.
module tb_alu_muldiv;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_muldiv_if #(.BIT_WIDTH(W)) bus ();

  alu_muldiv #(.BIT_WIDTH(W), .EARLY_OUT(1'b1)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_out(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    if (op[2] && b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
    if (op[2] && !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : a;
    case (op)
      3'd0:    p = sa * sb;
      3'd1:    p = sa * sb;
      3'd2:    p = sa * ub;
      3'd3:    p = ua * ub;
      3'd4:    p = sa / sb;
      3'd5:    p = ua / ub;
      3'd6:    p = sa % sb;
      default: p = ua % ub;
    endcase
    return (op[2] || op == 3'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op, check latency/result/flag, hold backpressure for 'hold' cycles, then drain.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    logic [31:0] exp, held;
    logic        exp_dz, busy_ok;
    int          exp_lat, lat;
    exp     = ref_out(op, a, b);
    exp_dz  = op[2] && (b == 32'h0);
    exp_lat = (exp_dz || (op[2] && !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
              ? 1 : W + 2;
    @(negedge clk);
    check("idle_in_ready", bus.in_ready, 1);
    bus.op = op; bus.in1 = a; bus.in2 = b; bus.in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    #1 bus.in_valid = 1'b0;
    busy_ok = 1'b1;
    while (!bus.out_valid && lat < 200) begin
      if (bus.in_ready) busy_ok = 1'b0;
      @(posedge clk);
      lat++;
      #1;
    end
    check($sformatf("latency op%0d", op), lat, exp_lat);
    check("busy_in_ready_low", busy_ok, 1);
    check($sformatf("result op%0d %h %h", op, a, b), bus.out, exp);
    check("div_zero", bus.div_zero, exp_dz);
    held = bus.out;
    for (int i = 0; i < hold; i++) begin
      bus.op = 3'd0; bus.in1 = $urandom; bus.in2 = $urandom; bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("bp_out_stable", bus.out, held);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_valid", bus.out_valid, 1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    check("drain_out_valid", bus.out_valid, 0);
    check("drain_in_ready", bus.in_ready, 1);
    check("drain_out_kept", bus.out, held);
  endtask

  logic [2:0]  d_op [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                             3'd4, 3'd6, 3'd4, 3'd6};
  logic [31:0] d_a  [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                             32'h1234_5678, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] d_b  [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF};

  initial begin
    logic saw_valid, lost_ready;
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = '0; bus.in1 = '0; bus.in2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out", bus.out, 0);
    check("rst_div_zero", bus.div_zero, 0);

    // Directed cases; the first one also exercises 5 cycles of backpressure.
    for (int i = 0; i < 12; i++) run_op(d_op[i], d_a[i], d_b[i], (i == 0) ? 5 : 0);

    // Flush mid-divide: in_valid on the flush edge must be ignored.
    @(negedge clk);
    bus.op = 3'd4; bus.in1 = 32'd1000; bus.in2 = 32'd3; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; bus.in_valid = 1'b1; bus.op = 3'd0;
    @(posedge clk);
    #1 flush = 1'b0; bus.in_valid = 1'b0;
    check("flush_in_ready", bus.in_ready, 1);
    check("flush_out_valid", bus.out_valid, 0);
    saw_valid = 1'b0; lost_ready = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) saw_valid = 1'b1;
      if (!bus.in_ready) lost_ready = 1'b1;
    end
    check("flush_no_result", saw_valid, 0);
    check("flush_stays_idle", lost_ready, 0);
    run_op(3'd0, 32'd3, 32'd5, 0);

    // Reset in the middle of a multiply clears the held result.
    @(negedge clk);
    bus.op = 3'd0; bus.in1 = 32'd9; bus.in2 = 32'd9; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out", bus.out, 0);
    check("midrst_div_zero", bus.div_zero, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), rnd_val(), rnd_val(), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
